panda_pipe_ctrl: RTL and testbench

- Central pipeline controller for the Panda 5-stage core. Generates the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.
- Handles three sequencing cases:
  - load-use stalls;
  - branch/jump redirects from EX, including redirects held while instruction memory is not ready;
  - multi-cycle EX operations, with a start/done handshake and a watchdog.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/panda_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_panda_pipe_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_pipe_ctrl.sv
// Pipeline controller for the Panda 5-stage core.
// Drives the PC / IF-ID / ID-EX / EX-MEM enables and flushes for three cases:
// load-use stalls, EX redirects (held while imem is busy) and multi-cycle EX ops.
// It also keeps a saturating counter of the cycles in which the PC is held.
// Pipeline controls are combinational so that a redirect takes effect in the same cycle.
// The error flag and the stall counter are registered.
module panda_pipe_ctrl #(
  parameter int unsigned MaxMultiCycles = 64,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [4:0]          id_rs1_addr_i,
  input  logic [4:0]          id_rs2_addr_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic                ex_valid_i,
  input  logic [4:0]          ex_rd_addr_i,
  input  logic                ex_rd_we_i,
  input  logic                ex_is_load_i,
  input  logic                ex_branch_i,
  input  logic                ex_jump_i,
  input  logic                branch_cond_i,
  input  logic [31:0]         branch_target_i,
  input  logic [31:0]         jump_target_i,
  input  logic                ex_multi_i,
  input  logic                ex_multi_done_i,
  input  logic                imem_ready_i,
  output logic                pc_en_o,
  output logic                pc_redirect_o,
  output logic [31:0]         pc_target_o,
  output logic                if_id_en_o,
  output logic                if_id_flush_o,
  output logic                id_ex_en_o,
  output logic                id_ex_flush_o,
  output logic                ex_mem_flush_o,
  output logic                ex_multi_start_o,
  output logic                err_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  localparam int unsigned WdWidth = (MaxMultiCycles > 1) ? $clog2(MaxMultiCycles) : 1;
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(MaxMultiCycles - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MULTI      = 2'd1,
    ST_REDIR_PEND = 2'd2
  } state_e;

  state_e              state_r, state_next_s;
  logic [31:0]         pend_tgt_r, pend_tgt_next_s;
  logic [WdWidth-1:0]  wd_r, wd_next_s;
  logic                err_r, err_set_s;
  logic [CntWidth-1:0] stall_cnt_r;

  logic        take_s;
  logic [31:0] tgt_s;
  logic        rs1_hit_s, rs2_hit_s, lu_s;

  // Redirect and load-use hazard detection from the EX and ID stage fields
  always_comb begin
    take_s    = ex_valid_i & (ex_jump_i | (ex_branch_i & branch_cond_i));
    tgt_s     = ex_jump_i ? jump_target_i : branch_target_i;
    rs1_hit_s = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit_s = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
    lu_s      = ex_valid_i & ex_is_load_i & ex_rd_we_i &
                (ex_rd_addr_i != 5'd0) & (rs1_hit_s | rs2_hit_s);
  end

  // Next-state and pipeline control decode
  always_comb begin
    pc_en_o          = 1'b1;
    pc_redirect_o    = 1'b0;
    pc_target_o      = 32'h0000_0000;
    if_id_en_o       = 1'b1;
    if_id_flush_o    = 1'b0;
    id_ex_en_o       = 1'b1;
    id_ex_flush_o    = 1'b0;
    ex_mem_flush_o   = 1'b0;
    ex_multi_start_o = 1'b0;
    state_next_s     = state_r;
    pend_tgt_next_s  = pend_tgt_r;
    wd_next_s        = wd_r;
    err_set_s        = 1'b0;

    if (!rst_ni) begin
      // Hold the whole pipeline and fill it with bubbles while in reset
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      ex_mem_flush_o  = 1'b1;
      state_next_s    = ST_RUN;
      pend_tgt_next_s = 32'h0000_0000;
      wd_next_s       = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ex_valid_i && ex_multi_i) begin
            ex_multi_start_o = 1'b1;
            pc_en_o          = 1'b0;
            if_id_en_o       = 1'b0;
            id_ex_en_o       = 1'b0;
            ex_mem_flush_o   = 1'b1;
            wd_next_s        = '0;
            state_next_s     = ST_MULTI;
          end else if (take_s && imem_ready_i) begin
            pc_redirect_o = 1'b1;
            pc_target_o   = tgt_s;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (take_s && !imem_ready_i) begin
            pend_tgt_next_s = tgt_s;
            pc_en_o         = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            state_next_s    = ST_REDIR_PEND;
          end else if (lu_s) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end else if (!imem_ready_i) begin
            pc_en_o       = 1'b0;
            if_id_flush_o = 1'b1;
          end else begin
            pc_en_o = 1'b1;
          end
        end

        ST_MULTI: begin
          pc_en_o        = 1'b0;
          if_id_en_o     = 1'b0;
          id_ex_en_o     = 1'b0;
          ex_mem_flush_o = 1'b1;
          wd_next_s      = wd_r + WdWidth'(1);
          if (ex_multi_done_i) begin
            // The result is captured into EX/MEM; ID/EX is flushed so the op does not run again
            pc_en_o        = 1'b1;
            if_id_en_o     = 1'b1;
            id_ex_en_o     = 1'b1;
            ex_mem_flush_o = 1'b0;
            id_ex_flush_o  = 1'b1;
            wd_next_s      = '0;
            state_next_s   = ST_RUN;
          end else if (wd_r == WdLimit) begin
            // Give up on the unit: resume without a result and flag the error
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            id_ex_en_o    = 1'b1;
            id_ex_flush_o = 1'b1;
            err_set_s     = 1'b1;
            wd_next_s     = '0;
            state_next_s  = ST_RUN;
          end else begin
            state_next_s = ST_MULTI;
          end
        end

        ST_REDIR_PEND: begin
          pc_en_o       = 1'b0;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (imem_ready_i) begin
            pc_en_o         = 1'b1;
            pc_redirect_o   = 1'b1;
            pc_target_o     = pend_tgt_r;
            pend_tgt_next_s = 32'h0000_0000;
            state_next_s    = ST_RUN;
          end else begin
            state_next_s = ST_REDIR_PEND;
          end
        end

        default: begin
          // An illegal state encoding is recovered by bubbling the pipe and returning to RUN
          pc_en_o        = 1'b0;
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
          wd_next_s      = '0;
          state_next_s   = ST_RUN;
        end
      endcase
    end
  end

  // State, pending redirect target and watchdog registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ST_RUN;
      pend_tgt_r <= 32'h0000_0000;
      wd_r       <= '0;
    end else begin
      state_r    <= state_next_s;
      pend_tgt_r <= pend_tgt_next_s;
      wd_r       <= wd_next_s;
    end
  end

  // Sticky watchdog error flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_r <= '0;
    end else if (!pc_en_o && (stall_cnt_r != {CntWidth{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CntWidth'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign err_o       = err_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_panda_pipe_ctrl.sv
// Directed testbench for panda_pipe_ctrl.
// The main instance uses the default parameters.
// A second instance has a 4-cycle watchdog and a 4-bit stall counter.
// It shares every input except the multi-cycle handshake.
module tb_panda_pipe_ctrl;

  logic        clk;
  logic        rst_ni;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we, ex_is_load, ex_branch, ex_jump, branch_cond;
  logic [31:0] branch_target, jump_target;
  logic        ex_multi, ex_multi_done, imem_ready;
  logic        ex_multi_w, ex_multi_done_w;

  logic        pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_flush, ex_multi_start, err;
  logic [31:0] pc_target;
  logic [31:0] stall_cnt;

  logic        w_pc_en, w_pc_redirect, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush;
  logic        w_ex_mem_flush, w_ex_multi_start, w_err;
  logic [31:0] w_pc_target;
  logic [3:0]  w_stall_cnt;

  int checks = 0;
  int errors = 0;

  panda_pipe_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd_addr), .ex_rd_we_i(ex_rd_we),
    .ex_is_load_i(ex_is_load), .ex_branch_i(ex_branch), .ex_jump_i(ex_jump),
    .branch_cond_i(branch_cond), .branch_target_i(branch_target), .jump_target_i(jump_target),
    .ex_multi_i(ex_multi), .ex_multi_done_i(ex_multi_done), .imem_ready_i(imem_ready),
    .pc_en_o(pc_en), .pc_redirect_o(pc_redirect), .pc_target_o(pc_target),
    .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_en_o(id_ex_en), .id_ex_flush_o(id_ex_flush),
    .ex_mem_flush_o(ex_mem_flush), .ex_multi_start_o(ex_multi_start),
    .err_o(err), .stall_cnt_o(stall_cnt)
  );

  panda_pipe_ctrl #(.MaxMultiCycles(4), .CntWidth(4)) dut_wd (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd_addr), .ex_rd_we_i(ex_rd_we),
    .ex_is_load_i(ex_is_load), .ex_branch_i(ex_branch), .ex_jump_i(ex_jump),
    .branch_cond_i(branch_cond), .branch_target_i(branch_target), .jump_target_i(jump_target),
    .ex_multi_i(ex_multi_w), .ex_multi_done_i(ex_multi_done_w), .imem_ready_i(imem_ready),
    .pc_en_o(w_pc_en), .pc_redirect_o(w_pc_redirect), .pc_target_o(w_pc_target),
    .if_id_en_o(w_if_id_en), .if_id_flush_o(w_if_id_flush),
    .id_ex_en_o(w_id_ex_en), .id_ex_flush_o(w_id_ex_flush),
    .ex_mem_flush_o(w_ex_mem_flush), .ex_multi_start_o(w_ex_multi_start),
    .err_o(w_err), .stall_cnt_o(w_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit the current inputs at the next rising edge, then move off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_rd_addr = 5'd0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
    ex_branch = 1'b0; ex_jump = 1'b0; branch_cond = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    ex_multi = 1'b0; ex_multi_done = 1'b0; ex_multi_w = 1'b0; ex_multi_done_w = 1'b0;
    imem_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    settle();
    // Outputs while in reset
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_if_id_en", if_id_en, 1'b0);
    chk("rst_id_ex_en", id_ex_en, 1'b0);
    chk("rst_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("rst_redirect", pc_redirect, 1'b0);
    chk("rst_target", pc_target, 32'h0);
    chk("rst_start", ex_multi_start, 1'b0);
    tick(); tick();
    rst_ni = 1'b1;
    settle();
    chk("run_pc_en", pc_en, 1'b1);
    chk("run_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b000);
    chk("run_err", err, 1'b0);
    chk("run_stall_cnt", stall_cnt, 32'd0);
    tick();

    // Load-use on rs1: exactly one bubble
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1'b1; id_rs2_addr = 5'd1; id_rs2_used = 1'b1;
    settle();
    chk("lu_pc_en", pc_en, 1'b0);
    chk("lu_if_id_en", if_id_en, 1'b0);
    chk("lu_id_ex_flush", id_ex_flush, 1'b1);
    chk("lu_id_ex_en", id_ex_en, 1'b1);
    tick();
    ex_valid = 1'b0;
    settle();
    chk("lu_after_en", {pc_en, if_id_en, id_ex_en, id_ex_flush}, 4'b1110);
    tick();
    // Load to x0 never stalls
    ex_valid = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    settle();
    chk("lu_x0_pc_en", pc_en, 1'b1);
    chk("lu_x0_flush", id_ex_flush, 1'b0);
    tick();
    // Load-use on rs2 only
    ex_rd_addr = 5'd7; id_rs1_used = 1'b0; id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
    settle();
    chk("lu_rs2_pc_en", pc_en, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("lu_stall_cnt", stall_cnt, 32'd2);

    // Taken branch, same-cycle redirect
    ex_valid = 1'b1; ex_branch = 1'b1; branch_cond = 1'b1; branch_target = 32'h100;
    settle();
    chk("br_redirect", pc_redirect, 1'b1);
    chk("br_target", pc_target, 32'h100);
    chk("br_pc_en", pc_en, 1'b1);
    chk("br_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    tick();
    branch_cond = 1'b0;
    settle();
    chk("br_nt_redirect", pc_redirect, 1'b0);
    chk("br_nt_flush", if_id_flush, 1'b0);
    tick();
    // Jump in a bubble slot is ignored
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b1; jump_target = 32'h2000;
    settle();
    chk("jmp_invalid_redirect", pc_redirect, 1'b0);
    tick();

    // Jump while imem is busy for three cycles
    ex_valid = 1'b1; imem_ready = 1'b0;
    settle();
    chk("pend_a_pc_en", pc_en, 1'b0);
    chk("pend_a_redirect", pc_redirect, 1'b0);
    chk("pend_a_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    tick();
    ex_valid = 1'b0; ex_jump = 1'b0;
    settle();
    chk("pend_b_pc_en", pc_en, 1'b0);
    tick();
    // A new taken branch in EX must not replace the held target
    ex_valid = 1'b1; ex_branch = 1'b1; branch_cond = 1'b1; branch_target = 32'h4444;
    settle();
    chk("pend_c_pc_en", pc_en, 1'b0);
    chk("pend_c_redirect", pc_redirect, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("pend_d_redirect", pc_redirect, 1'b1);
    chk("pend_d_target", pc_target, 32'h2000);
    chk("pend_d_pc_en", pc_en, 1'b1);
    tick();
    settle();
    chk("pend_stall_cnt", stall_cnt, 32'd5);
    chk("pend_after_redirect", pc_redirect, 1'b0);

    // Plain imem not ready
    imem_ready = 1'b0;
    settle();
    chk("nr_ctrl", {pc_en, if_id_flush, id_ex_flush}, 3'b010);
    tick();
    imem_ready = 1'b1;

    // Multi-cycle op, done on the fifth cycle after the start
    ex_valid = 1'b1; ex_multi = 1'b1;
    settle();
    chk("mc_start", ex_multi_start, 1'b1);
    chk("mc_start_ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_flush}, 4'b0001);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("mc_busy_start", ex_multi_start, 1'b0);
      chk("mc_busy_ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_flush}, 4'b0001);
      tick();
    end
    ex_multi_done = 1'b1;
    settle();
    chk("mc_done_ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_flush, id_ex_flush}, 5'b11101);
    chk("mc_done_start", ex_multi_start, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("mc_after_ctrl", {pc_en, ex_mem_flush, ex_multi_start}, 3'b100);
    chk("mc_stall_cnt", stall_cnt, 32'd11);

    // Multi-cycle op beats a simultaneous load-use hazard
    ex_valid = 1'b1; ex_multi = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    settle();
    chk("prio_start", ex_multi_start, 1'b1);
    chk("prio_no_bubble", id_ex_flush, 1'b0);
    tick();
    ex_multi_done = 1'b1;
    settle();
    chk("prio_in_multi", {ex_multi_start, ex_mem_flush, id_ex_flush}, 3'b001);
    tick();
    idle_inputs();
    settle();
    chk("prio_stall_cnt", stall_cnt, 32'd12);

    // Watchdog on the 4-cycle instance
    ex_valid = 1'b1; ex_multi_w = 1'b1;
    settle();
    chk("wd_start", w_ex_multi_start, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wd_busy_flush", {w_ex_mem_flush, w_id_ex_flush, w_pc_en}, 3'b100);
      chk("wd_busy_err", w_err, 1'b0);
      tick();
    end
    settle();
    chk("wd_timeout_flush", w_id_ex_flush, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk("wd_err", w_err, 1'b1);
    chk("wd_back_run", {w_pc_en, w_ex_multi_start}, 2'b10);
    tick();
    settle();
    chk("wd_err_sticky", w_err, 1'b1);

    // Reset in the middle of a multi-cycle op
    ex_valid = 1'b1; ex_multi_w = 1'b1;
    tick();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    chk("mrst_err", w_err, 1'b0);
    chk("mrst_run", {w_pc_en, w_ex_multi_start, w_ex_mem_flush}, 3'b100);
    chk("mrst_stall_cnt", stall_cnt, 32'd0);
    tick();

    // Done on the watchdog limit cycle counts as done
    ex_valid = 1'b1; ex_multi_w = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    ex_multi_done_w = 1'b1;
    settle();
    chk("wd_late_done_flush", w_ex_mem_flush, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("wd_late_done_err", w_err, 1'b0);

    // Counter saturation on the 4-bit instance
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    settle();
    chk("sat_reach", w_stall_cnt, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    settle();
    chk("sat_hold", w_stall_cnt, 4'hF);
    chk("sat_main_cnt", stall_cnt, 32'd18);
    imem_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
